// File: rtl/puf_eval_ctrl_pkg.sv
// Shared definitions for the arbiter-PUF evaluation controller:
// FSM state encodings, the default LFSR tap mask and synchroniser depth.
package puf_eval_ctrl_pkg;

    // FSM state encodings
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOW  = 3'd1;
    localparam logic [2:0] HIGH = 3'd2;
    localparam logic [2:0] SYNC = 3'd3;
    localparam logic [2:0] ACC  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    // Default Galois tap mask for a 32-bit challenge
    localparam logic [31:0] POLY_DEFAULT = 32'h8020_0003;

    // Depth of the arb_q synchroniser; SYNC state waits this many cycles
    localparam int SYNC_STAGES = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Galois LFSR that produces the mux-chain challenge. A zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module puf_lfsr
    import puf_eval_ctrl_pkg::*;
#(
    parameter int                CHAL_W = 32,
    parameter logic [CHAL_W-1:0] POLY   = CHAL_W'(POLY_DEFAULT)
) (
    input  logic              c,
    input  logic              rn,
    input  logic              load,
    input  logic [CHAL_W-1:0] seed,
    input  logic              step,
    output logic [CHAL_W-1:0] q
);

    logic [CHAL_W-1:0] lfsr_q;
    logic [CHAL_W-1:0] lfsr_d;

    // Next value: load a non-zero seed, or shift right and fold in taps on lsb=1
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? CHAL_W'(1) : seed;
        end else if (step) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
        end
    end

    // LFSR state register
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer. For each response bit it launches the
// race VOTES times, samples the synchronised arbiter output after each
// race, majority-votes the samples and flags non-unanimous bits. The
// finished response is offered on a valid/ready handshake.
module puf_eval_ctrl
    import puf_eval_ctrl_pkg::*;
#(
    parameter int                CHAL_W = 32,
    parameter int                RESP_W = 16,
    parameter int                VOTES  = 7,
    parameter int                SETTLE = 8,
    parameter logic [CHAL_W-1:0] POLY   = CHAL_W'(POLY_DEFAULT)
) (
    input  logic              c,
    input  logic              rn,
    input  logic              start,
    input  logic [CHAL_W-1:0] seed,
    output logic              busy,
    output logic [CHAL_W-1:0] chal,
    output logic              launch,
    input  logic              arb_q,
    output logic [RESP_W-1:0] resp,
    output logic [RESP_W-1:0] unstable,
    output logic              resp_valid,
    input  logic              resp_ready
);

    localparam int VW = $clog2(VOTES + 1);
    localparam int BW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int CW = $clog2(max2(SETTLE, SYNC_STAGES) + 1);

    // One shared phase counter times LOW, HIGH and the SYNC flush
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] SYNC_LAST   = CW'(SYNC_STAGES - 1);
    localparam logic [VW-1:0] VOTE_HALF   = VW'(VOTES / 2);
    localparam logic [VW-1:0] VOTE_ALL    = VW'(VOTES);
    localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_W - 1);

    logic [2:0]        state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [VW-1:0]     vote_q,    vote_d;
    logic [VW-1:0]     ones_q,    ones_d;
    logic [BW-1:0]     bit_q,     bit_d;
    logic [RESP_W-1:0] resp_q,    resp_d;
    logic [RESP_W-1:0] unst_q,    unst_d;
    logic              busy_q,    busy_d;
    logic              valid_q,   valid_d;
    logic              launch_q,  launch_d;
    logic              s1_q, s2_q;
    logic [VW-1:0]     ones_fin;
    logic              lfsr_load;
    logic              lfsr_step;

    // Challenge generator; its register drives the mux select lines directly
    puf_lfsr #(
        .CHAL_W (CHAL_W),
        .POLY   (POLY)
    ) u_lfsr (
        .c     (c),
        .rn    (rn),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .q     (chal)
    );

    // Two-flop synchroniser for the asynchronous arbiter output
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= arb_q;
            s2_q <= s1_q;
        end
    end

    // Sequencing, vote accumulation and response assembly
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vote_d    = vote_q;
        ones_d    = ones_q;
        bit_d     = bit_q;
        resp_d    = resp_q;
        unst_d    = unst_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        // Vote total including the sample taken this cycle
        ones_fin  = ones_q + VW'(s2_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    cnt_d     = '0;
                    vote_d    = '0;
                    ones_d    = '0;
                    bit_d     = '0;
                    resp_d    = '0;
                    unst_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = LOW;
                end
            end

            LOW: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HIGH: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = SYNC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Launch stays high while the arbiter result walks through s1/s2
            SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    cnt_d   = '0;
                    state_d = ACC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ACC: begin
                if (int'(vote_q) < VOTES - 1) begin
                    ones_d  = ones_fin;
                    vote_d  = vote_q + 1'b1;
                    state_d = LOW;
                end else begin
                    resp_d[bit_q] = (ones_fin > VOTE_HALF);
                    unst_d[bit_q] = (ones_fin != '0) && (ones_fin != VOTE_ALL);
                    lfsr_step     = 1'b1;
                    vote_d        = '0;
                    ones_d        = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = LOW;
                    end
                end
            end

            // resp_valid rises one cycle after entering DONE
            DONE: begin
                valid_d = 1'b1;
                if (valid_q && resp_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Launch is registered from the next state so it lines up with the phase
        launch_d = (state_d == HIGH) || (state_d == SYNC) || (state_d == ACC);
    end

    // Controller state registers; reset also drops launch asynchronously
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vote_q   <= '0;
            ones_q   <= '0;
            bit_q    <= '0;
            resp_q   <= '0;
            unst_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vote_q   <= vote_d;
            ones_q   <= ones_d;
            bit_q    <= bit_d;
            resp_q   <= resp_d;
            unst_q   <= unst_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            launch_q <= launch_d;
        end
    end

    assign busy       = busy_q;
    assign launch     = launch_q;
    assign resp       = resp_q;
    assign unstable   = unst_q;
    assign resp_valid = valid_q;

endmodule
